// File: rtl/prog_seq_pkg.sv
// Shared definitions for the program sequencer: FSM states, ALU opcodes,
// the halt instruction encoding and default program entry points.
package prog_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_e;

   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_ADDI  = 4'h1;
   localparam logic [3:0] OP_SUB   = 4'h2;
   localparam logic [3:0] OP_SHL   = 4'h3;
   localparam logic [3:0] OP_MEM   = 4'h4;
   localparam logic [3:0] OP_BEQ0  = 4'h5;
   localparam logic [3:0] OP_CMP4  = 4'h6;
   localparam logic [3:0] OP_XOR   = 4'h7;
   localparam logic [3:0] OP_CLR   = 4'h8;
   localparam logic [3:0] OP_OR    = 4'h9;
   localparam logic [3:0] OP_NOT   = 4'hA;
   localparam logic [3:0] OP_JMP   = 4'hB;
   localparam logic [3:0] OP_MAGIC = 4'hC;
   localparam logic [3:0] OP_SLT   = 4'hD;
   localparam logic [3:0] OP_ABS   = 4'hE;
   localparam logic [3:0] OP_NOP   = 4'hF;

   localparam logic [8:0] HALT_INSTR = 9'h1FF;

   localparam logic [7:0] PROG0_ADDR_DEF = 8'h00;
   localparam logic [7:0] PROG1_ADDR_DEF = 8'h5E;
   localparam logic [7:0] PROG2_ADDR_DEF = 8'hAB;

endpackage

// File: rtl/prog_seq_decode.sv
// Combinational instruction classifier.
//   instr_i     : latched instruction (opcode in the top 4 bits)
//   writes_rf_o : instruction writes the register file in WB
//   is_mem_o    : data-memory access (load or store)
//   is_add_o    : add instruction, overflow is tracked
//   is_halt_o   : instruction is the halt encoding
module prog_seq_decode
   import prog_seq_pkg::*;
#(
   parameter int unsigned INSTR_W = 9
) (
   input  logic [INSTR_W-1:0] instr_i,
   output logic               writes_rf_o,
   output logic               is_mem_o,
   output logic               is_add_o,
   output logic               is_halt_o
);

   logic [3:0] op;

   assign op = instr_i[INSTR_W-1 -: 4];

   always_comb begin
      writes_rf_o = 1'b1;
      unique case (op)
         OP_BEQ0, OP_JMP, OP_NOP: writes_rf_o = 1'b0;
         // bit 0 selects store (1) or load (0); only loads write back
         OP_MEM:                  writes_rf_o = ~instr_i[0];
         default:                 writes_rf_o = 1'b1;
      endcase
   end

   assign is_mem_o  = (op == OP_MEM);
   assign is_add_o  = (op == OP_ADD);
   assign is_halt_o = (instr_i == INSTR_W'(HALT_INSTR));

endmodule

// File: rtl/prog_seq_ctrl.sv
// Fetch/decode/execute/writeback sequencer for the 8-bit ALU datapath.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   start, prog_sel             : launch a program (entry 0..2) from IDLE/HALT
//   busy, done                  : running / halted status
//   imem_req/addr/ack/rdata     : instruction fetch handshake
//   instr_o, alu_opcode         : latched instruction and its opcode
//   start_addr_o                : current program entry point
//   alu_out_i, branch_taken_i,
//   overflow_i                  : ALU results sampled in EXEC
//   rf_we                       : one-cycle register-file write strobe
//   dmem_req/we/ack             : data-memory handshake
//   ovf_sticky, instr_count     : sticky add overflow, retired count
module prog_seq_ctrl
   import prog_seq_pkg::*;
#(
   parameter int unsigned        PC_W       = 8,
   parameter int unsigned        INSTR_W    = 9,
   parameter int unsigned        CNT_W      = 16,
   parameter logic [PC_W-1:0]    PROG0_ADDR = PROG0_ADDR_DEF,
   parameter logic [PC_W-1:0]    PROG1_ADDR = PROG1_ADDR_DEF,
   parameter logic [PC_W-1:0]    PROG2_ADDR = PROG2_ADDR_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [1:0]         prog_sel,
   output logic               busy,
   output logic               done,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr_o,
   output logic [3:0]         alu_opcode,
   output logic [PC_W-1:0]    start_addr_o,
   input  logic [PC_W-1:0]    alu_out_i,
   input  logic               branch_taken_i,
   input  logic               overflow_i,
   output logic               rf_we,
   output logic               dmem_req,
   output logic               dmem_we,
   input  logic               dmem_ack,
   output logic               ovf_sticky,
   output logic [CNT_W-1:0]   instr_count
);

   state_e             state_q, state_d;
   logic [PC_W-1:0]    pc_q, pc_d;
   logic [PC_W-1:0]    start_addr_q, start_addr_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [3:0]         opcode_q, opcode_d;
   logic               ovf_q, ovf_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               br_q, br_d;
   logic [PC_W-1:0]    tgt_q, tgt_d;

   logic               dec_writes_rf;
   logic               dec_is_mem;
   logic               dec_is_add;
   logic               dec_is_halt;
   logic [PC_W-1:0]    sel_addr;
   logic               launch;

   prog_seq_decode #(
      .INSTR_W (INSTR_W)
   ) u_decode (
      .instr_i     (instr_q),
      .writes_rf_o (dec_writes_rf),
      .is_mem_o    (dec_is_mem),
      .is_add_o    (dec_is_add),
      .is_halt_o   (dec_is_halt)
   );

   always_comb begin
      sel_addr = PROG0_ADDR;
      unique case (prog_sel)
         2'd1:    sel_addr = PROG1_ADDR;
         2'd2:    sel_addr = PROG2_ADDR;
         default: sel_addr = PROG0_ADDR;
      endcase
   end

   // prog_sel = 3 is reserved and never launches
   assign launch = start && (prog_sel != 2'd3);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      start_addr_d = start_addr_q;
      instr_d      = instr_q;
      opcode_d     = opcode_q;
      ovf_d        = ovf_q;
      cnt_d        = cnt_q;
      br_d         = br_q;
      tgt_d        = tgt_q;
      unique case (state_q)
         S_IDLE, S_HALT: begin
            if (launch) begin
               state_d      = S_FETCH;
               pc_d         = sel_addr;
               start_addr_d = sel_addr;
               ovf_d        = 1'b0;
               cnt_d        = '0;
            end
         end
         S_FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            opcode_d = instr_q[INSTR_W-1 -: 4];
            // halt leaves PC on the halt instruction and retires nothing
            state_d  = dec_is_halt ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            br_d  = branch_taken_i;
            tgt_d = alu_out_i;
            if (dec_is_add) begin
               ovf_d = ovf_q | overflow_i;
            end
            state_d = dec_is_mem ? S_MEM : S_WB;
         end
         S_MEM: begin
            if (dmem_ack) begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            pc_d = br_q ? tgt_q : pc_q + PC_W'(1);
            if (cnt_q != '1) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         pc_q         <= '0;
         start_addr_q <= '0;
         instr_q      <= '0;
         opcode_q     <= '1;
         ovf_q        <= 1'b0;
         cnt_q        <= '0;
         br_q         <= 1'b0;
         tgt_q        <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         start_addr_q <= start_addr_d;
         instr_q      <= instr_d;
         opcode_q     <= opcode_d;
         ovf_q        <= ovf_d;
         cnt_q        <= cnt_d;
         br_q         <= br_d;
         tgt_q        <= tgt_d;
      end
   end

   // Strobes decode straight from the state register so an async reset
   // drops them in the same instant.
   assign busy         = (state_q != S_IDLE) && (state_q != S_HALT);
   assign done         = (state_q == S_HALT);
   assign imem_req     = (state_q == S_FETCH);
   assign imem_addr    = pc_q;
   assign dmem_req     = (state_q == S_MEM);
   assign dmem_we      = dmem_req && instr_q[0];
   assign rf_we        = (state_q == S_WB) && dec_writes_rf;
   assign instr_o      = instr_q;
   assign alu_opcode   = opcode_q;
   assign start_addr_o = start_addr_q;
   assign ovf_sticky   = ovf_q;
   assign instr_count  = cnt_q;

endmodule

// File: doc/prog_seq_ctrl.md
Name: prog_seq_ctrl

Overview:
- Multi-cycle fetch/decode/execute/writeback sequencer for the 8-bit ALU datapath.
- Owns the 8-bit PC and selects one of three program entry points.
- Latches each 9-bit instruction and drives the ALU opcode and start-address inputs.
- Consumes ALU branch/overflow results, and sequences instruction-memory, data-memory and register-file write strobes.

Parameters:
- PC_W, 8, program counter / address width
- INSTR_W, 9, instruction width
- CNT_W, 16, retired-instruction counter width
- PROG0_ADDR, 8'h00, entry point for prog_sel=0
- PROG1_ADDR, 8'h5E, entry point for prog_sel=1
- PROG2_ADDR, 8'hAB, entry point for prog_sel=2

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  launch program; sampled only in IDLE/HALT
- prog_sel  in  2  program select; 3 is reserved
- busy  out  1  high from launch until halt
- done  out  1  high in HALT until the next launch
- imem_req  out  1  instruction-fetch request
- imem_addr  out  PC_W  fetch address (= PC)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  INSTR_W  fetched instruction
- instr_o  out  INSTR_W  latched current instruction, to decoder/regfile
- alu_opcode  out  4  latched instr[8:5]
- start_addr_o  out  PC_W  current program entry point, to ALU label lookup
- alu_out_i  in  8  ALU result; branch target for beq0/jmp
- branch_taken_i  in  1  ALU branch decision
- overflow_i  in  1  ALU add overflow
- rf_we  out  1  one-cycle register-file write strobe
- dmem_req  out  1  data-memory request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
- dmem_ack  in  1  data access complete
- ovf_sticky  out  1  sticky OR of overflow_i captured on add instructions
- instr_count  out  CNT_W  retired instructions, saturating

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; PC=0, instr_o=0, alu_opcode=4'hF, start_addr_o=0.
  - All of busy, done, imem_req, rf_we, dmem_req, dmem_we, ovf_sticky are 0; instr_count=0.
  - Reset mid-fetch or mid-memory access drops imem_req/dmem_req immediately; a late ack after reset is ignored.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE/HALT:
  - start=1 with prog_sel in 0..2: PC and start_addr_o load PROGn_ADDR; ovf_sticky and instr_count clear; done=0; busy=1; next state FETCH.
  - start with prog_sel=3 is ignored. start in any other state is ignored.
- FETCH:
  - imem_req=1 and imem_addr=PC, held stable until imem_ack.
  - On ack (same cycle allowed): instr_o <= imem_rdata; next state DECODE. No timeout.
- DECODE (1 cycle): alu_opcode <= instr_o[8:5]. instr_o=9'h1FF is HALT_INSTR: next state HALT, with no PC update, no count and no rf_we.
- EXEC (1 cycle):
  - Capture branch_taken_i and alu_out_i.
  - If opcode=4'h0, ovf_sticky |= overflow_i.
  - Opcode 4'h4 goes to MEM; all others go to WB.
- MEM:
  - dmem_req=1, dmem_we=instr_o[0], held until dmem_ack; then WB.
- WB (1 cycle):
  - rf_we=1 for opcodes 0,1,2,3,6,7,8,9,A,C,D,E and for loads (4 with instr[0]=0).
  - rf_we=0 for beq0(5), jmp(B), nop(F) and stores.
  - PC <= captured alu_out if branch taken, else PC+1. Wrap is mod 256: 8'hFF+1 = 8'h00.
  - instr_count++, saturating at all-ones. Next state FETCH.
- HALT: busy=0, done=1; PC holds the address of the halt instruction.
- Latency:
  - ALU/branch instruction = 4 cycles with zero-wait imem.
  - Memory instruction = 5 cycles, plus wait states.
- Simultaneous overflow_i on a non-add opcode: ignored.

Decomposition:
- Package prog_seq_pkg:
  - state enum.
  - 4-bit opcode localparams: ADD=0, ADDI=1, SUB=2, SHL=3, MEM=4, BEQ0=5, CMP4=6, XOR=7, CLR=8, OR=9, NOT=A, JMP=B, MAGIC=C, SLT=D, ABS=E, NOP=F.
  - HALT_INSTR=9'h1FF.
  - PROGn_ADDR defaults.
- One sub-module, prog_seq_decode: combinational opcode -> {writes_rf, is_mem, is_add, is_halt}.

Test Plan:
- prog_sel=1, start; imem returns ADD then HALT_INSTR with 0 wait -> imem_addr 8'h5E then 8'h5F; rf_we single pulse in cycle 4; done=1; instr_count=1.
- Jmp at PC 8'h10 with branch_taken_i=1, alu_out_i=8'h6C -> next imem_addr=8'h6C; rf_we stays 0.
- Beq0 at PC 8'hFF with taken=0 -> next imem_addr=8'h00 (wrap); instr_count increments.
- Load (opcode 4, bit0=0) with dmem_ack after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0; rf_we pulses the cycle after ack. A store instead gives dmem_we=1 and no rf_we.
- ADD with overflow_i=1, followed by SUB with overflow_i=1 -> ovf_sticky=1 after ADD EXEC. Restarting with start, prog_sel=0 clears it to 0.
- rst_n low while imem_req=1 awaiting ack -> imem_req=0 immediately, state IDLE, busy=0. start with prog_sel=3 -> no fetch issued.
